// File: rtl/prog_loader.sv
// LC-3 program loader / boot sequencer: writes streamed images into memory,
// then strobes the PC load and releases the core.
module prog_loader #(
    parameter int unsigned        DATA_W   = 16,
    parameter logic [DATA_W-1:0]  START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              load_done,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_value,
    output logic              cpu_run,
    output logic [DATA_W-1:0] word_count,
    output logic              err_wrap
);

    localparam logic [DATA_W-1:0] MAX_W = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_BOOT  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t             r_state, w_state_d;
    logic [DATA_W-1:0]  r_addr, w_addr_d;
    logic [DATA_W-1:0]  r_wdata, w_wdata_d;
    logic [DATA_W-1:0]  r_count, w_count_d;
    logic               r_last, w_last_d;
    logic               r_err, w_err_d;

    // Header is only taken in IDLE when no boot is requested; boot wins the tie.
    assign in_ready   = ((r_state == S_IDLE) && !load_done) || (r_state == S_LOAD);
    assign mem_req    = (r_state == S_WRITE);
    assign pc_load    = (r_state == S_BOOT);
    assign cpu_run    = (r_state == S_RUN);
    assign pc_value   = START_PC;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign word_count = r_count;
    assign err_wrap   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_count <= w_count_d;
            r_last  <= w_last_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_count_d = r_count;
        w_last_d  = r_last;
        w_err_d   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (load_done) begin
                    w_state_d = S_BOOT;
                end else if (in_valid) begin
                    w_addr_d = in_data;
                    if (!in_last) w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_wdata_d = in_data;
                    w_last_d  = in_last;
                    w_state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address auto-increments so consecutive words land contiguously.
                if (mem_ack) begin
                    w_addr_d = r_addr + DATA_W'(1);
                    if (r_addr == MAX_W) w_err_d = 1'b1;
                    if (r_count != MAX_W) w_count_d = r_count + DATA_W'(1);
                    w_state_d = r_last ? S_IDLE : S_LOAD;
                end
            end
            S_BOOT:  w_state_d = S_RUN;
            S_RUN:   w_state_d = S_RUN;
            default: w_state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a reference model queues expected memory
// writes per streamed image; a monitor compares every presented write.
module tb_prog_loader;

    localparam logic [15:0] START_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, load_done;
    logic [15:0] in_data;
    logic        mem_req, mem_ack, pc_load, cpu_run, err_wrap;
    logic [15:0] mem_addr, mem_wdata, pc_value, word_count;

    prog_loader #(.DATA_W(16), .START_PC(START_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .load_done(load_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .pc_load(pc_load), .pc_value(pc_value), .cpu_run(cpu_run),
        .word_count(word_count), .err_wrap(err_wrap)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [15:0] img[$];
    logic [15:0] m_addr;
    int          m_count;
    bit          m_err;
    int          n_checks = 0;
    int          n_err = 0;
    bit          hold_ack = 1'b0;
    int          fixed_delay = -1;
    int          wait_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    // Reference model: each data word goes to the running address, which wraps.
    function automatic void exp_write(input logic [15:0] d);
        exp_q.push_back({m_addr, d});
        if (m_addr == 16'hFFFF) m_err = 1'b1;
        m_addr = m_addr + 16'd1;
        if (m_count < 65535) m_count++;
    endfunction

    // Memory responder: programmable ack latency, random ack noise when idle.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || hold_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt > 0) begin
                    mem_ack = 1'b0;
                    wait_cnt--;
                end else begin
                    mem_ack  = 1'b1;
                    wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: every cycle with a request must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
                end else begin
                    chk("write_addr_data", {mem_addr, mem_wdata}, exp_q[0]);
                    if (mem_ack) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last);
        int t = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++t > 200) begin
                chk("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_image(input logic [15:0] a);
        m_addr = a;
        send(a, img.size() == 0);
        foreach (img[i]) begin
            exp_write(img[i]);
            send(img[i], i == img.size() - 1);
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h0;
        load_done = 1'b0;
        exp_q.delete();
        m_count   = 0;
        m_err     = 1'b0;
        #1;
        chk("rst_mem_req",   32'(mem_req),    32'd0);
        chk("rst_pc_load",   32'(pc_load),    32'd0);
        chk("rst_cpu_run",   32'(cpu_run),    32'd0);
        chk("rst_err_wrap",  32'(err_wrap),   32'd0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 32'd0);
        chk("rst_count",     32'(word_count), 32'd0);
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        hold_ack    = 1'b0;
        fixed_delay = -1;
        wait_cnt    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drain writes, then request boot with a competing stream word present.
    task automatic do_boot();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("pre_boot_count", 32'(word_count), 32'(m_count));
        chk("pre_boot_err",   32'(err_wrap),   32'(m_err));
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        in_last   = 1'b0;
        load_done = 1'b1;
        @(negedge clk);
        chk("boot_req_in_ready", 32'(in_ready), 32'd0);
        chk("boot_req_pc_load",  32'(pc_load),  32'd0);
        @(negedge clk);
        chk("boot_pc_load",  32'(pc_load),  32'd1);
        chk("boot_pc_value", 32'(pc_value), 32'(START_PC));
        chk("boot_cpu_run",  32'(cpu_run),  32'd0);
        @(negedge clk);
        chk("run_pc_load", 32'(pc_load), 32'd0);
        chk("run_cpu_run", 32'(cpu_run), 32'd1);
        load_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("run_in_ready", {30'd0, in_ready, pc_load}, 32'd0);
            chk("run_hold",     32'(cpu_run), 32'd1);
        end
        chk("run_count", 32'(word_count), 32'(m_count));
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        do_reset();

        img = '{16'h1234, 16'h5678};
        send_image(16'h3000);
        do_boot();

        do_reset();
        fixed_delay = 3;
        wait_cnt    = 3;
        img = '{16'hAAAA};
        send_image(16'h0000);
        img = '{16'hBBBB, 16'hCCCC};
        send_image(16'h0200);
        fixed_delay = -1;
        img = '{16'h1111, 16'h2222};
        send_image(16'hFFFF);
        for (int k = 0; k < 8; k++) begin
            int n = int'($urandom_range(0, 4));
            img.delete();
            for (int j = 0; j < n; j++) img.push_back(16'($urandom));
            send_image(16'($urandom));
        end
        do_boot();

        do_reset();
        img.delete();
        send_image(16'h4000);
        do_boot();

        do_reset();
        hold_ack = 1'b1;
        img = '{16'h9999};
        send_image(16'h0100);
        chk("held_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0100});
        do_reset();
        img = '{16'h1357};
        send_image(16'h0500);
        do_boot();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
